// File: rtl/deser_fifo.sv
// Serial-to-parallel deserializer feeding a word FIFO behind a valid/ready handshake.
// Optional feature macro DESER_PARITY_EN: one even-parity bit per frame plus a per-word o_parity_err flag.
module deser_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_bit,
  input  logic                   i_bit_valid,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_word,
  output logic                   o_word_valid,
  input  logic                   i_word_ready,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overrun
`ifdef DESER_PARITY_EN
  ,
  output logic                   o_parity_err
`endif
);

`ifdef DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = WIDTH + PAR;
  localparam int CW    = $clog2(FRAME);
  localparam int EW    = WIDTH + PAR;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_shift;
  logic [EW-1:0]    w_entry;
  logic             w_sample;
  logic             w_last;
  logic             w_push;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_overrun;
  logic [EW-1:0]    w_head;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  assign w_sample = i_bit_valid & ~i_flush;
  assign w_last   = (r_cnt == CW'(FRAME - 1));
  assign w_push   = w_sample & w_last;
  assign w_shift  = (MSB_FIRST != 0) ? {r_sr[WIDTH-2:0], i_bit}
                                     : {i_bit, r_sr[WIDTH-1:1]};

  // The final sample of a frame never lands in r_sr: it goes straight into the pushed entry.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_bit_valid) begin
      if (w_last) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else begin
        r_sr  <= w_shift;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef DESER_PARITY_EN
  logic r_par;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush || w_push) begin
      r_par <= 1'b0;
    end else if (w_sample) begin
      r_par <= r_par ^ i_bit;
    end
  end

  assign w_entry = {r_par ^ i_bit, r_sr};
`else
  assign w_entry = w_shift;
`endif

  assign o_word_valid = (r_level != '0);
  assign w_full       = (r_level == LW'(DEPTH));
  assign w_pop        = o_word_valid & i_word_ready;
  assign w_wr         = w_push & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_wr && w_pop) r_level <= r_level - LW'(1);
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  // NOTE: storage is not reset; outputs are masked while empty, so stale entries are never visible.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= w_entry;
  end

  assign w_head    = r_mem[r_rptr];
  assign o_word    = o_word_valid ? w_head[WIDTH-1:0] : '0;
  assign o_level   = r_level;
  assign o_overrun = r_overrun;
`ifdef DESER_PARITY_EN
  assign o_parity_err = o_word_valid & w_head[WIDTH];
`endif

endmodule

// File: tb/tb_deser_fifo.sv
// Scoreboard bench for deser_fifo: MSB-first and LSB-first instances share one serial stream.
// A queue-based reference model predicts queued words; a negedge monitor checks them.
module tb_deser_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef struct {
    logic [WIDTH-1:0] msb;
    logic [WIDTH-1:0] lsb;
    logic             perr;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sbit = 1'b0;
  logic bit_valid = 1'b0;
  logic flush = 1'b0;
  logic word_ready = 1'b0;

  logic [WIDTH-1:0] word_m, word_l;
  logic             valid_m, valid_l;
  logic [$clog2(DEPTH):0] level_m, level_l;
  logic             ovr_m, ovr_l;
  logic             perr_m, perr_l;

  int n_pass = 0;
  int n_total = 0;

  entry_t exp_q[$];
  logic   bits_q[$];
  logic   exp_ovr = 1'b0;
  logic   pend_push = 1'b0;
  logic   pend_drop = 1'b0;
  entry_t pend_e;

  always #5 clk = ~clk;

  deser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_bit(sbit), .i_bit_valid(bit_valid), .i_flush(flush),
    .o_word(word_m), .o_word_valid(valid_m), .i_word_ready(word_ready),
    .o_level(level_m), .o_overrun(ovr_m)
`ifdef DESER_PARITY_EN
    , .o_parity_err(perr_m)
`endif
  );

  deser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_bit(sbit), .i_bit_valid(bit_valid), .i_flush(flush),
    .o_word(word_l), .o_word_valid(valid_l), .i_word_ready(word_ready),
    .o_level(level_l), .o_overrun(ovr_l)
`ifdef DESER_PARITY_EN
    , .o_parity_err(perr_l)
`endif
  );

`ifndef DESER_PARITY_EN
  assign perr_m = 1'b0;
  assign perr_l = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Reference model: bits collect into a frame; the word is formed by bit position,
  // then queued if the FIFO has room (or the consumer takes the head that same cycle).
  task automatic model_decide(input logic b, input logic v, input logic f,
                              input logic rd, input logic rs);
    entry_t e;
    pend_push = 1'b0;
    pend_drop = 1'b0;
    if (rs) begin
      exp_q.delete();
      bits_q.delete();
      exp_ovr = 1'b0;
      return;
    end
    if (f) begin
      bits_q.delete();
      return;
    end
    if (!v) return;
    bits_q.push_back(b);
    if (bits_q.size() == FRAME) begin
      e.perr = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        e.msb[WIDTH-1-i] = bits_q[i];
        e.lsb[i]         = bits_q[i];
      end
      for (int i = 0; i < FRAME; i++) e.perr = e.perr ^ bits_q[i];
      bits_q.delete();
      if (exp_q.size() < DEPTH || (rd && exp_q.size() > 0)) begin
        pend_push = 1'b1;
        pend_e    = e;
      end else begin
        pend_drop = 1'b1;
      end
    end
  endtask

  task automatic cyc(input logic b, input logic v, input logic f,
                     input logic rd, input logic rs);
    sbit = b; bit_valid = v; flush = f; word_ready = rd; rst = rs;
    model_decide(b, v, f, rd, rs);
    @(posedge clk);
    #1;
    if (pend_push) exp_q.push_back(pend_e);
    if (pend_drop) exp_ovr = 1'b1;
    pend_push = 1'b0;
    pend_drop = 1'b0;
  endtask

  // Bits are sent w[WIDTH-1] first; an even-parity bit follows when parity is built in.
  task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input logic rd,
                           input logic bad_par);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      cyc(w[i], 1'b1, 1'b0, rd, 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, rd, 1'b0);
    end
`ifdef DESER_PARITY_EN
    cyc((^w) ^ bad_par, 1'b1, 1'b0, rd, 1'b0);
`else
    if (bad_par) cyc(1'b0, 1'b0, 1'b0, rd, 1'b0);
`endif
  endtask

  task automatic pop_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("valid_msb", {31'd0, valid_m}, {31'd0, exp_q.size() > 0});
      check("valid_lsb", {31'd0, valid_l}, {31'd0, exp_q.size() > 0});
      check("level", {29'd0, level_m}, exp_q.size());
      check("level_lsb", {29'd0, level_l}, exp_q.size());
      check("overrun", {31'd0, ovr_m}, {31'd0, exp_ovr});
      check("overrun_lsb", {31'd0, ovr_l}, {31'd0, exp_ovr});
      if (exp_q.size() > 0 && valid_m && valid_l) begin
        check("head_msb", {24'd0, word_m}, {24'd0, exp_q[0].msb});
        check("head_lsb", {24'd0, word_l}, {24'd0, exp_q[0].lsb});
`ifdef DESER_PARITY_EN
        check("perr_msb", {31'd0, perr_m}, {31'd0, exp_q[0].perr});
        check("perr_lsb", {31'd0, perr_l}, {31'd0, exp_q[0].perr});
`endif
        if (word_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("rst_word", {24'd0, word_m}, 32'h0);
    check("rst_valid", {31'd0, valid_m}, 32'h0);
    check("rst_level", {29'd0, level_m}, 32'h0);
    check("rst_overrun", {31'd0, ovr_m}, 32'h0);
    check("rst_perr", {31'd0, perr_m}, 32'h0);

    // Back-to-back frame
    send_word(8'hA5, 0, 1'b0, 1'b0);
    check("t1_word", {24'd0, word_m}, 32'hA5);
    check("t1_level", {29'd0, level_m}, 32'd1);
    pop_cycles(1);
    check("t1_drained", {29'd0, level_m}, 32'd0);

    // Gaps of two idle cycles between bits
    send_word(8'hA5, 2, 1'b0, 1'b0);
    check("t2_word", {24'd0, word_m}, 32'hA5);
    pop_cycles(1);

    // Partial frame discarded by flush
    send_word(8'hA5, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    send_word(8'h3C, 0, 1'b0, 1'b0);
    check("t3_level", {29'd0, level_m}, 32'd2);
    check("t3_head", {24'd0, word_m}, 32'hA5);
    pop_cycles(1);
    check("t3_second", {24'd0, word_m}, 32'h3C);
    pop_cycles(1);

    // Flush on the frame's final position wins over completion
    for (int i = 0; i < FRAME - 1; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("flush_last_level", {29'd0, level_m}, 32'd0);
    send_word(8'h5A, 0, 1'b0, 1'b0);
    check("flush_last_next", {24'd0, word_m}, 32'h5A);
    pop_cycles(1);

    // Overrun on a full FIFO
    for (int k = 1; k <= 5; k++) send_word(WIDTH'(k), 0, 1'b0, 1'b0);
    check("t4_level", {29'd0, level_m}, 32'd4);
    check("t4_overrun", {31'd0, ovr_m}, 32'd1);
    pop_cycles(5);
    check("t4_empty", {29'd0, level_m}, 32'd0);
    check("t4_sticky", {31'd0, ovr_m}, 32'd1);

    // LSB-first decode, then reset mid-frame
    cyc(0, 0, 0, 0, 1);
    send_word(8'hA0, 0, 1'b0, 1'b0);
    check("t5_lsb_word", {24'd0, word_l}, 32'h05);
    check("t5_msb_word", {24'd0, word_m}, 32'hA0);
    pop_cycles(1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("t5_rst_level", {29'd0, level_l}, 32'd0);
    check("t5_rst_valid", {31'd0, valid_l}, 32'd0);
    send_word(8'hC3, 0, 1'b0, 1'b0);
    check("t5_clean", {24'd0, word_m}, 32'hC3);
    pop_cycles(1);

`ifdef DESER_PARITY_EN
    send_word(8'hA5, 0, 1'b0, 1'b0);
    check("par_good_word", {24'd0, word_m}, 32'hA5);
    check("par_good_err", {31'd0, perr_m}, 32'd0);
    pop_cycles(1);
    send_word(8'hA5, 0, 1'b0, 1'b1);
    check("par_bad_word", {24'd0, word_m}, 32'hA5);
    check("par_bad_err", {31'd0, perr_m}, 32'd1);
    pop_cycles(1);
`endif

    // Randomised traffic; the monitor checks every cycle
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0,
          1'($urandom_range(0, 1)),
          $urandom_range(0, 149) == 0);
    end
    pop_cycles(DEPTH + 2);
    check("final_level", {29'd0, level_m}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/deser_fifo.md
# deser_fifo

Parametrised serial-to-parallel deserializer with an output word FIFO. It assembles WIDTH-bit words from a qualified 1-bit serial stream, with selectable bit order and a flush that discards a partial word. Completed words are queued for a downstream consumer behind a valid/ready handshake. It is the generalised successor of the team's fixed 8-bit byte collector and sits between a serial receive front-end and word-oriented logic.

## Interface
- WIDTH, 8: bits per word; minimum 2.
- DEPTH, 4: output FIFO entries; power of two, minimum 2.
- MSB_FIRST, 1: 1 = first received bit lands in word[WIDTH-1]; 0 = first bit lands in word[0].

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- bit  in  1  serial data bit.
- bit_valid  in  1  bit is sampled only when high.
- flush  in  1  discards the partial word; has priority over bit_valid.
- word  out  WIDTH  head-of-FIFO word; valid only while word_valid = 1.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word.
- level  out  $clog2(DEPTH)+1  number of words queued.
- overrun  out  1  sticky flag: a completed word was dropped because the FIFO was full.
- parity_err  out  1  parity error flag for the head word; present only with DESER_PARITY_EN.

## Operation
- Shift register sr[WIDTH-1:0] and bit counter cnt.
  - cnt runs 0..WIDTH-1 without parity, 0..WIDTH with parity.
- Sampled bit (bit_valid=1, flush=0):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], bit}.
  - MSB_FIRST=0: sr <= {bit, sr[WIDTH-1:1]}.
  - cnt increments.
- Frame completes on the sampled bit with cnt at its maximum value:
  - The assembled word, including the current bit, is pushed to the FIFO.
  - cnt wraps to 0 and sr clears to 0.
- Cycles with bit_valid=0 leave sr and cnt unchanged.
- Flush:
  - sr <= 0, cnt <= 0. The bit on the flush cycle is ignored.
  - FIFO contents, level and overrun are unchanged.
- Pop: when word_valid && word_ready, the head is removed.
- Push when full:
  - Accepted if a pop occurs in the same cycle; level is unchanged.
  - Otherwise the word is dropped and overrun <= 1.
  - overrun clears only on rst.
- Push and pop in the same cycle on a non-full, non-empty FIFO: level is unchanged.
- FIFO pointers wrap modulo DEPTH. level saturates at DEPTH by construction.

## Timing
- Reset values: word=0, word_valid=0, level=0, overrun=0, parity_err=0. sr, cnt and FIFO pointers are also 0.
- rst mid-frame or with a full FIFO: all state clears at that edge. Outputs read reset values in the next cycle, and any partial word or queued words are lost.
- Latency: word_valid and level update in the cycle after the edge that samples the last bit of a frame. word is read combinationally from the head entry.
- Handshake:
  - word and parity_err remain stable while word_valid=1 and word_ready=0.
  - word_ready while word_valid=0 has no effect.
- A frame completing on the same edge as flush is not pushed, because flush wins.
- Back-to-back frames with bit_valid held high push one word every WIDTH cycles, or every WIDTH+1 cycles with parity.

## Configuration
- DESER_PARITY_EN defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - The FIFO stores WIDTH+1 bits per entry: the word plus its error flag.
  - parity_err = 1 when the XOR of the data bits and the parity bit is 1. The word is still queued.
  - A flush during the parity bit position discards the frame.
- DESER_PARITY_EN undefined:
  - Frames are WIDTH bits.
  - The parity_err port and parity storage do not exist.

## Test plan
- WIDTH=8, MSB_FIRST=1, DEPTH=4: after rst, bits 1,0,1,0,0,1,0,1 on consecutive cycles with bit_valid=1 -> word_valid=1 one cycle after the 8th edge, word=8'hA5, level=1.
- Same bits with bit_valid low for 2 cycles between each bit -> word=8'hA5 on completion; no push occurs during the gaps.
- After one queued 8'hA5 (not popped), send 1,1,1, assert flush for 1 cycle, then send 0x3C MSB-first -> 8'hA5 is still the head; level=2 and the second entry is 8'h3C.
- word_ready=0, send words 0x01..0x05 -> level=4 and overrun=1 after the 5th frame. Then raise word_ready -> pops return 01, 02, 03, 04; 0x05 is lost and overrun stays 1 until rst.
- MSB_FIRST=0 instance: bits 1,0,1,0,0,0,0,0 -> word=8'h05. Additionally, assert rst after 4 bits of a frame -> level=0 and word_valid=0 next cycle, and the next full frame decodes cleanly.
- With DESER_PARITY_EN: 0xA5 followed by parity bit 0 -> parity_err=0. 0xA5 followed by parity bit 1 -> parity_err=1. In both cases word=8'hA5.
